// File: rtl/regfile_pkg.sv
// Shared types and the write-match helper for the multi-port register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int N_WRITE  = 2;
  localparam int ADDR_MAX = 16;

  typedef struct packed {
    logic hit;
    logic port;
  } wmatch_t;

  // Higher-numbered write port overrides lower ones, so port 1 wins a collision.
  function automatic wmatch_t write_match(
    input logic [N_WRITE-1:0]               wen,
    input logic [N_WRITE-1:0][ADDR_MAX-1:0] waddr,
    input logic [ADDR_MAX-1:0]              addr
  );
    wmatch_t m;
    m = '0;
    for (int i = 0; i < N_WRITE; i++) begin
      if (wen[i] && (waddr[i] == addr)) begin
        m.hit  = 1'b1;
        m.port = i[0];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 zero, write-first bypass and busy reporting.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                            ready,
  input  logic [AW-1:0]                   raddr,
  input  logic [XLEN-1:0]                 mem_rdata,
  input  logic                            busy_bit,
  input  logic [N_WRITE-1:0]              wen,
  input  logic [N_WRITE-1:0][AW-1:0]      waddr,
  input  logic [N_WRITE-1:0][XLEN-1:0]    wdata,
  output logic [XLEN-1:0]                 rdata,
  output logic                            rbusy
);

  logic [N_WRITE-1:0][ADDR_MAX-1:0] waddr_x;
  wmatch_t                          m;

  always_comb begin
    for (int i = 0; i < N_WRITE; i++) waddr_x[i] = ADDR_MAX'(waddr[i]);
    m = write_match(wen, waddr_x, ADDR_MAX'(raddr));
  end

  // A forwarded write supersedes the pending producer, so it masks busy.
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (ready && (raddr != '0)) begin
      rdata = m.hit ? wdata[m.port] : mem_rdata;
      rbusy = busy_bit & ~m.hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sweep and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int DEPTH  = 32,
  parameter  int N_READ = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_done,
  input  logic [N_READ-1:0][AW-1:0]     raddr,
  output logic [N_READ-1:0][XLEN-1:0]   rdata,
  output logic [N_READ-1:0]             rbusy,
  input  logic [N_WRITE-1:0]            wen,
  input  logic [N_WRITE-1:0][AW-1:0]    waddr,
  input  logic [N_WRITE-1:0][XLEN-1:0]  wdata,
  input  logic                          lock_en,
  input  logic [AW-1:0]                 lock_addr
);

  state_e                           state_q, state_d;
  logic [AW-1:0]                    cnt_q, cnt_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;
  logic [XLEN-1:0]                  mem [DEPTH];
  logic                             ready;
  logic [N_WRITE-1:0]               wen_g;
  logic [N_WRITE-1:0][ADDR_MAX-1:0] waddr_x;
  wmatch_t                          clr_m;

  assign ready     = (state_q == READY);
  assign init_done = ready;
  assign wen_g     = ready ? wen : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
    end
  end

  // Lock is applied after the clears so a same-cycle reissue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    clr_m  = '0;
    for (int i = 0; i < N_WRITE; i++) waddr_x[i] = ADDR_MAX'(waddr[i]);
    for (int r = 1; r < DEPTH; r++) begin
      clr_m = write_match(wen_g, waddr_x, ADDR_MAX'(r));
      if (clr_m.hit) busy_d[r] = 1'b0;
    end
    if (ready && lock_en && (lock_addr != '0)) busy_d[lock_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage carries no reset; the sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < N_WRITE; i++) begin
        if (wen[i] && (waddr[i] != '0)) mem[waddr[i]] <= wdata[i];
      end
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    regfile_read_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rd (
      .ready     (ready),
      .raddr     (raddr[p]),
      .mem_rdata (mem[raddr[p]]),
      .busy_bit  (busy_q[raddr[p]]),
      .wen       (wen_g),
      .waddr     (waddr),
      .wdata     (wdata),
      .rdata     (rdata[p]),
      .rbusy     (rbusy[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default config (A) and 64/16/3 variant (B).
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic             init_done_a;
  logic [1:0][4:0]  raddr_a;
  logic [1:0][31:0] rdata_a;
  logic [1:0]       rbusy_a;
  logic [1:0]       wen_a;
  logic [1:0][4:0]  waddr_a;
  logic [1:0][31:0] wdata_a;
  logic             lock_en_a;
  logic [4:0]       lock_addr_a;

  logic             init_done_b;
  logic [2:0][3:0]  raddr_b;
  logic [2:0][63:0] rdata_b;
  logic [2:0]       rbusy_b;
  logic [1:0]       wen_b;
  logic [1:0][3:0]  waddr_b;
  logic [1:0][63:0] wdata_b;
  logic             lock_en_b;
  logic [3:0]       lock_addr_b;

  regfile_mp u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .init_done (init_done_a),
    .raddr     (raddr_a),
    .rdata     (rdata_a),
    .rbusy     (rbusy_a),
    .wen       (wen_a),
    .waddr     (waddr_a),
    .wdata     (wdata_a),
    .lock_en   (lock_en_a),
    .lock_addr (lock_addr_a)
  );

  regfile_mp #(.XLEN(64), .DEPTH(16), .N_READ(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .init_done (init_done_b),
    .raddr     (raddr_b),
    .rdata     (rdata_b),
    .rbusy     (rbusy_b),
    .wen       (wen_b),
    .waddr     (waddr_b),
    .wdata     (wdata_b),
    .lock_en   (lock_en_b),
    .lock_addr (lock_addr_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        dut;
    logic        busy;
    logic [1:0]  port;
    logic [63:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_rd(input string tag, input logic dut, input logic busy,
                           input int port, input logic [63:0] val);
    exp_t e;
    e.dut  = dut;
    e.busy = busy;
    e.port = port[1:0];
    e.val  = val;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t        e;
    string       t;
    logic [63:0] got;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (!e.dut) got = e.busy ? 64'(rbusy_a[e.port[0]]) : 64'(rdata_a[e.port[0]]);
      else        got = e.busy ? 64'(rbusy_b[e.port])    : rdata_b[e.port];
      check(t, got, e.val);
    end
  endtask

  task automatic wait_ready(input logic dut, output int edges);
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (dut ? init_done_b : init_done_a) break;
    end
  endtask

  task automatic idle_a();
    wen_a = '0; waddr_a = '0; wdata_a = '0; lock_en_a = 1'b0; lock_addr_a = '0;
  endtask

  task automatic idle_b();
    wen_b = '0; waddr_b = '0; wdata_b = '0; lock_en_b = 1'b0; lock_addr_b = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges;
    idle_a();
    idle_b();
    raddr_a = '0;
    raddr_b = '0;
    repeat (2) @(negedge clk);

    // ---------------- config A: reset state ----------------
    raddr_a[0] = 5'd5; raddr_a[1] = 5'd3;
    expect_rd("a_rst_rdata0", 0, 0, 0, 0);
    expect_rd("a_rst_rbusy0", 0, 1, 0, 0);
    #1; drain();
    check("a_rst_init_done", 64'(init_done_a), 0);

    // sweep with a write and lock to x5 that must be ignored
    wen_a[0] = 1'b1; waddr_a[0] = 5'd5; wdata_a[0] = 32'hDEAD;
    lock_en_a = 1'b1; lock_addr_a = 5'd5;
    rst_a = 1'b0;
    expect_rd("a_init_no_bypass", 0, 0, 0, 0);
    #1; drain();
    wait_ready(0, edges);
    idle_a();
    check("a_sweep_edges", 64'(edges), 32);

    @(negedge clk);
    expect_rd("a_x5_after_init", 0, 0, 0, 0);
    expect_rd("a_x5_busy_after_init", 0, 1, 0, 0);
    #1; drain();

    // basic write/read with bypass
    @(negedge clk);
    wen_a[0] = 1'b1; waddr_a[0] = 5'd3; wdata_a[0] = 32'h1234_5678;
    raddr_a[0] = 5'd3; raddr_a[1] = 5'd3;
    expect_rd("a_x3_bypass_p0", 0, 0, 0, 64'h1234_5678);
    expect_rd("a_x3_bypass_p1", 0, 0, 1, 64'h1234_5678);
    #1; drain();
    @(negedge clk);
    idle_a();
    expect_rd("a_x3_store_p0", 0, 0, 0, 64'h1234_5678);
    expect_rd("a_x3_store_p1", 0, 0, 1, 64'h1234_5678);
    #1; drain();

    // x0 stays zero
    @(negedge clk);
    wen_a[0] = 1'b1; waddr_a[0] = 5'd0; wdata_a[0] = 32'hFFFF_FFFF;
    raddr_a[0] = 5'd0; raddr_a[1] = 5'd3;
    expect_rd("a_x0_bypass", 0, 0, 0, 0);
    expect_rd("a_x3_indep", 0, 0, 1, 64'h1234_5678);
    #1; drain();
    @(negedge clk);
    idle_a();
    expect_rd("a_x0_store", 0, 0, 0, 0);
    #1; drain();

    // dual-write collision: port 1 wins
    @(negedge clk);
    wen_a = 2'b11;
    waddr_a[0] = 5'd7; wdata_a[0] = 32'hAAAA;
    waddr_a[1] = 5'd7; wdata_a[1] = 32'h5555;
    raddr_a[0] = 5'd7; raddr_a[1] = 5'd7;
    expect_rd("a_x7_coll_bypass", 0, 0, 0, 64'h5555);
    #1; drain();
    @(negedge clk);
    idle_a();
    expect_rd("a_x7_coll_store", 0, 0, 1, 64'h5555);
    #1; drain();

    // scoreboard: lock, then write clears, then lock+write keeps busy
    @(negedge clk);
    lock_en_a = 1'b1; lock_addr_a = 5'd9; raddr_a[0] = 5'd9;
    expect_rd("a_x9_lock_same", 0, 1, 0, 0);
    #1; drain();
    @(negedge clk);
    idle_a();
    expect_rd("a_x9_lock_next", 0, 1, 0, 1);
    #1; drain();
    @(negedge clk);
    wen_a[1] = 1'b1; waddr_a[1] = 5'd9; wdata_a[1] = 32'h42;
    expect_rd("a_x9_wr_rbusy", 0, 1, 0, 0);
    expect_rd("a_x9_wr_rdata", 0, 0, 0, 64'h42);
    #1; drain();
    @(negedge clk);
    idle_a();
    expect_rd("a_x9_cleared", 0, 1, 0, 0);
    expect_rd("a_x9_stored", 0, 0, 0, 64'h42);
    #1; drain();
    @(negedge clk);
    wen_a[0] = 1'b1; waddr_a[0] = 5'd9; wdata_a[0] = 32'h77;
    lock_en_a = 1'b1; lock_addr_a = 5'd9;
    expect_rd("a_x9_lockwr_fwd", 0, 1, 0, 0);
    #1; drain();
    @(negedge clk);
    idle_a();
    expect_rd("a_x9_lockwr_busy", 0, 1, 0, 1);
    expect_rd("a_x9_lockwr_data", 0, 0, 0, 64'h77);
    #1; drain();

    // reset from READY, then again mid-sweep at cycle 10
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("a_rst2_init_done", 64'(init_done_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("a_midsweep_init_done", 64'(init_done_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    wait_ready(0, edges);
    check("a_resweep_edges", 64'(edges), 32);
    @(negedge clk);
    raddr_a[0] = 5'd9; raddr_a[1] = 5'd3;
    expect_rd("a_x9_busy_cleared", 0, 1, 0, 0);
    expect_rd("a_x9_data_cleared", 0, 0, 0, 0);
    expect_rd("a_x3_data_cleared", 0, 0, 1, 0);
    #1; drain();

    // ---------------- config B: 64-bit, 16 deep, 3 read ports ----------------
    raddr_b[0] = 4'd3; raddr_b[1] = 4'd0; raddr_b[2] = 4'd3;
    expect_rd("b_rst_rdata2", 1, 0, 2, 0);
    #1; drain();
    check("b_rst_init_done", 64'(init_done_b), 0);
    @(negedge clk);
    rst_b = 1'b0;
    wait_ready(1, edges);
    check("b_sweep_edges", 64'(edges), 16);

    @(negedge clk);
    wen_b[0] = 1'b1; waddr_b[0] = 4'd3; wdata_b[0] = 64'h0123_4567_89AB_CDEF;
    expect_rd("b_x3_bypass_p0", 1, 0, 0, 64'h0123_4567_89AB_CDEF);
    expect_rd("b_x0_p1", 1, 0, 1, 0);
    expect_rd("b_x3_bypass_p2", 1, 0, 2, 64'h0123_4567_89AB_CDEF);
    #1; drain();
    @(negedge clk);
    idle_b();
    expect_rd("b_x3_store_p2", 1, 0, 2, 64'h0123_4567_89AB_CDEF);
    #1; drain();

    @(negedge clk);
    wen_b = 2'b11;
    waddr_b[0] = 4'd7; wdata_b[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    waddr_b[1] = 4'd7; wdata_b[1] = 64'h5555_5555_5555_5555;
    raddr_b[0] = 4'd7; raddr_b[1] = 4'd15; raddr_b[2] = 4'd7;
    expect_rd("b_x7_coll_bypass", 1, 0, 2, 64'h5555_5555_5555_5555);
    #1; drain();
    @(negedge clk);
    idle_b();
    wen_b[1] = 1'b1; waddr_b[1] = 4'd15; wdata_b[1] = 64'hFEED_0000_0000_BEEF;
    expect_rd("b_x7_coll_store", 1, 0, 0, 64'h5555_5555_5555_5555);
    expect_rd("b_x15_bypass", 1, 0, 1, 64'hFEED_0000_0000_BEEF);
    #1; drain();
    @(negedge clk);
    idle_b();
    expect_rd("b_x15_store", 1, 0, 1, 64'hFEED_0000_0000_BEEF);
    #1; drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
